// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite bus types plus SRAM slave state and lane helpers
package ahb;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } type_htrans;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } type_hsize;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } type_hburst;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } type_slv_state;

    // Little-endian lane enables; unsupported sizes enable nothing.
    function automatic logic [3:0] byte_strobe(type_hsize size, logic [1:0] addr);
        case (size)
            HSIZE_BYTE: byte_strobe = 4'b0001 << addr;
            HSIZE_HALF: byte_strobe = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: byte_strobe = 4'b1111;
            default:    byte_strobe = 4'b0000;
        endcase
    endfunction

    function automatic logic addr_ok(type_hsize size, logic [1:0] addr);
        case (size)
            HSIZE_BYTE: addr_ok = 1'b1;
            HSIZE_HALF: addr_ok = ~addr[0];
            HSIZE_WORD: addr_ok = (addr == 2'b00);
            default:    addr_ok = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/ahb_slave_sram_if.sv
// rtl/ahb_slave_sram_if.sv - AHB-Lite master/slave signal bundle
interface ahb_slave_sram_if;
    import ahb::*;

    logic        HSEL;
    logic        HREADY;
    type_htrans  HTRANS;
    logic [31:0] HADDR;
    type_hsize   HSIZE;
    type_hburst  HBURST;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HTRANS, HADDR, HSIZE, HBURST, HWRITE, HWDATA,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HREADY, HTRANS, HADDR, HSIZE, HBURST, HWRITE, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - word-organised SRAM, async read, byte-enabled sync write
module ahb_sram_mem #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic [3:0]                   we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);
    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/ahb_slave_sram.sv
// rtl/ahb_slave_sram.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR
module ahb_slave_sram
    import ahb::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_slave_sram_if.slave bus
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    type_slv_state    state;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] lat_idx;
    logic [1:0]       lat_addr;
    type_hsize        lat_size;
    logic             lat_write;
    logic             hreadyout_r;
    logic             hresp_r;

    logic [31:0]      offset;
    logic             accept;
    logic             acc_err;
    type_slv_state    acc_state;
    logic [3:0]       wr_strobe;
    logic [31:0]      mem_rdata;
    logic             unused_bits;

    assign offset = bus.HADDR - BASE_ADDR;

    // Only sample while we are not stalling the bus ourselves.
    assign accept = bus.HSEL & bus.HREADY & hreadyout_r &
                    ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

    // Addresses below BASE_ADDR wrap to large offsets and land in the range error.
    assign acc_err   = ({1'b0, offset} >= MEM_BYTES) || !addr_ok(bus.HSIZE, offset[1:0]);
    assign acc_state = acc_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

    assign unused_bits = ^{bus.HBURST, offset[31:IDX_W+2]};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            lat_idx     <= '0;
            lat_addr    <= 2'b00;
            lat_size    <= HSIZE_BYTE;
            lat_write   <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            if (accept) begin
                lat_idx   <= offset[IDX_W+1:2];
                lat_addr  <= offset[1:0];
                lat_size  <= bus.HSIZE;
                lat_write <= bus.HWRITE;
            end
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                        state       <= S_DATA;
                        wait_cnt    <= 4'd0;
                        hreadyout_r <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ERR1: begin
                    state       <= S_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        state       <= acc_state;
                        hreadyout_r <= (acc_state == S_DATA);
                        hresp_r     <= (acc_state == S_ERR1);
                    end else begin
                        state       <= S_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Errored transfers never reach S_DATA, so they can never write.
    assign wr_strobe = (state == S_DATA && lat_write) ? byte_strobe(lat_size, lat_addr) : 4'b0000;

    ahb_sram_mem #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk  (HCLK),
        .we   (wr_strobe),
        .addr (lat_idx),
        .wdata(bus.HWDATA),
        .rdata(mem_rdata)
    );

    assign bus.HREADYOUT = hreadyout_r;
    assign bus.HRESP     = hresp_r;
    assign bus.HRDATA    = (state == S_DATA && !lat_write) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_ahb_slave_sram.sv
// tb/tb_ahb_slave_sram.sv - pipelined AHB driver, vector table, random model checks
module tb_ahb_slave_sram;
    import ahb::*;

    localparam int          MW        = 64;
    localparam int          MEM_BYTES = MW * 4;
    localparam logic [31:0] BASE0     = 32'h0000_0000;
    localparam logic [31:0] BASE1     = 32'h0000_1000;
    localparam int          WS0       = 0;
    localparam int          WS1       = 2;

    typedef struct {
        bit          dut;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_resp;
        int          exp_waits;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        sel = 1'b0;
    logic        block = 1'b0;
    logic        t_hsel = 1'b0;
    logic        t_hwrite = 1'b0;
    type_htrans  t_htrans = HTRANS_IDLE;
    logic [31:0] t_haddr = 32'h0;
    logic [31:0] t_hwdata = 32'h0;
    logic [2:0]  t_hsize = 3'd0;

    int          tests = 0;
    int          fails = 0;
    vec_t        tbl[$];
    vec_t        prog[$];
    logic [7:0]  ref_mem [2][MEM_BYTES];

    always #5 HCLK = ~HCLK;

    ahb_slave_sram_if if0();
    ahb_slave_sram_if if1();

    assign if0.HSEL   = t_hsel & ~sel;
    assign if1.HSEL   = t_hsel & sel;
    assign if0.HREADY = if0.HREADYOUT & ~block;
    assign if1.HREADY = if1.HREADYOUT & ~block;
    assign if0.HTRANS = t_htrans;
    assign if1.HTRANS = t_htrans;
    assign if0.HADDR  = t_haddr;
    assign if1.HADDR  = t_haddr;
    assign if0.HSIZE  = type_hsize'(t_hsize);
    assign if1.HSIZE  = type_hsize'(t_hsize);
    assign if0.HBURST = HBURST_INCR4;
    assign if1.HBURST = HBURST_INCR4;
    assign if0.HWRITE = t_hwrite;
    assign if1.HWRITE = t_hwrite;
    assign if0.HWDATA = t_hwdata;
    assign if1.HWDATA = t_hwdata;

    wire        o_ready = sel ? if1.HREADYOUT : if0.HREADYOUT;
    wire        o_resp  = sel ? if1.HRESP : if0.HRESP;
    wire [31:0] o_rdata = sel ? if1.HRDATA : if0.HRDATA;

    ahb_slave_sram #(.MEM_WORDS(MW), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(if0.slave));
    ahb_slave_sram #(.MEM_WORDS(MW), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(if1.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tv(input bit d, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input bit resp);
        vec_t v;
        v.dut = d; v.wr = wr; v.size = sz; v.addr = addr; v.wdata = wd;
        v.exp_rdata = rd; v.exp_resp = resp;
        v.exp_waits = resp ? 1 : (d ? WS1 : WS0);
        tbl.push_back(v);
    endtask

    // Byte-addressed reference: range/alignment rules decide ERROR, lanes decide bytes.
    task automatic model_push(input bit d, input bit wr, input logic [2:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd);
        vec_t        v;
        logic [31:0] off;
        int          nb;
        bit          err;
        off = addr - (d ? BASE1 : BASE0);
        nb  = 1 << sz;
        err = (off >= MEM_BYTES) || (sz > 3'd2) || ((addr % nb) != 0);
        v.dut = d; v.wr = wr; v.size = sz; v.addr = addr; v.wdata = wd;
        v.exp_resp  = err;
        v.exp_waits = err ? 1 : (d ? WS1 : WS0);
        v.exp_rdata = 32'h0;
        if (!err && wr)
            for (int k = 0; k < nb; k++) ref_mem[d][off + k] = wd[8 * ((off + k) % 4) +: 8];
        if (!err && !wr)
            for (int k = 0; k < 4; k++) v.exp_rdata[8*k +: 8] = ref_mem[d][(off & ~32'h3) + k];
        prog.push_back(v);
    endtask

    // Address phase of beat n+1 overlaps the data phase of beat n; starts and ends just after posedge.
    task automatic run_prog(input string tag);
        int   ai = 0, di = 0, waits = 0, cyc = 0;
        bit   have_dp = 0, rdy, abort = 0;
        logic resp_act = 1'b0;
        vec_t dp;
        if (prog.size() == 0) return;
        sel = prog[0].dut;
        while ((ai < prog.size() || have_dp) && cyc < 5000) begin
            cyc++;
            if (ai < prog.size()) begin
                t_hsel   = 1'b1;
                t_htrans = (ai == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                t_haddr  = prog[ai].addr;
                t_hsize  = prog[ai].size;
                t_hwrite = prog[ai].wr;
            end else begin
                t_hsel   = 1'b0;
                t_htrans = HTRANS_IDLE;
            end
            t_hwdata = have_dp ? dp.wdata : 32'h0;
            @(negedge HCLK);
            rdy = o_ready;
            if (have_dp) begin
                if (o_resp !== dp.exp_resp) resp_act = o_resp;
                if (rdy) begin
                    chk($sformatf("%s[%0d] waits", tag, di), waits, dp.exp_waits);
                    chk($sformatf("%s[%0d] hresp", tag, di), {31'h0, resp_act}, {31'h0, dp.exp_resp});
                    chk($sformatf("%s[%0d] hrdata", tag, di), o_rdata, dp.exp_rdata);
                end else begin
                    waits++;
                    if (waits > 16) begin
                        chk($sformatf("%s[%0d] wait_timeout", tag, di), waits, dp.exp_waits);
                        abort = 1;
                    end
                end
            end
            @(posedge HCLK);
            #1;
            if (abort) break;
            if (rdy) begin
                if (ai < prog.size()) begin
                    dp = prog[ai]; di = ai; ai++;
                    have_dp = 1; waits = 0; resp_act = dp.exp_resp;
                end else begin
                    have_dp = 0;
                end
            end
        end
        if (cyc >= 5000) chk({tag, " cycle_budget"}, cyc, 0);
        t_hsel   = 1'b0;
        t_htrans = HTRANS_IDLE;
        prog.delete();
    endtask

    task automatic chk_idle(input string name);
        chk({name, " hreadyout"}, {31'h0, o_ready}, 32'h1);
        chk({name, " hresp"}, {31'h0, o_resp}, 32'h0);
        chk({name, " hrdata"}, o_rdata, 32'h0);
    endtask

    initial begin
        tv(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        tv(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        for (int i = 0; i < 4; i++) tv(0, 1, 3'd2, 32'h20 + 4 * i, i + 1, 32'h0, 0);
        for (int i = 0; i < 4; i++) tv(0, 0, 3'd2, 32'h20 + 4 * i, 32'h0, i + 1, 0);
        tv(0, 1, 3'd2, 32'h40, 32'h11223344, 32'h0, 0);
        tv(0, 1, 3'd0, 32'h41, 32'h0000AA00, 32'h0, 0);
        tv(0, 1, 3'd1, 32'h42, 32'h55660000, 32'h0, 0);
        tv(0, 0, 3'd2, 32'h40, 32'h0, 32'h5566AA44, 0);
        tv(0, 1, 3'd2, 32'h00, 32'h0BADF00D, 32'h0, 0);
        tv(0, 0, 3'd2, 32'h100, 32'h0, 32'h0, 1);
        tv(0, 0, 3'd1, 32'h03, 32'h0, 32'h0, 1);
        tv(0, 1, 3'd1, 32'h03, 32'hFFFFFFFF, 32'h0, 1);
        tv(0, 1, 3'd2, 32'h100, 32'hFFFFFFFF, 32'h0, 1);
        tv(0, 1, 3'd2, 32'h02, 32'hFFFFFFFF, 32'h0, 1);
        tv(0, 0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
        tv(0, 0, 3'd2, 32'h00, 32'h0, 32'h0BADF00D, 0);
        tv(0, 0, 3'd0, 32'h43, 32'h0, 32'h5566AA44, 0);
        tv(0, 0, 3'd1, 32'h12, 32'h0, 32'hDEADBEEF, 0);
        tv(0, 1, 3'd2, 32'hFC, 32'hA5A5_0001, 32'h0, 0);
        tv(0, 0, 3'd2, 32'hFC, 32'h0, 32'hA5A5_0001, 0);
        tv(1, 1, 3'd2, 32'h1010, 32'hCAFEF00D, 32'h0, 0);
        tv(1, 0, 3'd2, 32'h1010, 32'h0, 32'hCAFEF00D, 0);
        tv(1, 1, 3'd0, 32'h1013, 32'h77000000, 32'h0, 0);
        tv(1, 0, 3'd2, 32'h1010, 32'h0, 32'h77FEF00D, 0);
        tv(1, 0, 3'd2, 32'h1100, 32'h0, 32'h0, 1);
        tv(1, 0, 3'd2, 32'h0FFC, 32'h0, 32'h0, 1);
        tv(1, 1, 3'd1, 32'h1011, 32'hFFFFFFFF, 32'h0, 1);
        tv(1, 0, 3'd2, 32'h1010, 32'h0, 32'h77FEF00D, 0);
        tv(1, 1, 3'd2, 32'h10FC, 32'hDEAD0001, 32'h0, 0);
        tv(1, 0, 3'd2, 32'h10FC, 32'h0, 32'hDEAD0001, 0);

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        sel = 1'b0; chk_idle("reset dut0");
        sel = 1'b1; chk_idle("reset dut1");
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < tbl.size(); i++) if (tbl[i].dut == d[0]) prog.push_back(tbl[i]);
            run_prog($sformatf("table%0d", d));
        end

        // BUSY, unselected NONSEQ and HREADY-blocked NONSEQ must all leave memory alone.
        sel = 1'b0;
        t_hsel = 1'b1; t_htrans = HTRANS_BUSY; t_haddr = 32'h10; t_hwrite = 1'b1; t_hsize = 3'd2;
        @(posedge HCLK); #1;
        t_hsel = 1'b0; t_htrans = HTRANS_NONSEQ; t_hwdata = 32'h1111_1111;
        @(negedge HCLK); chk_idle("busy");
        @(posedge HCLK); #1;
        block = 1'b1; t_hsel = 1'b1;
        @(negedge HCLK); chk_idle("nosel");
        @(posedge HCLK); #1;
        block = 1'b0; t_hsel = 1'b0; t_htrans = HTRANS_IDLE;
        @(negedge HCLK); chk_idle("blocked");
        @(posedge HCLK); #1;
        tv(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        prog.push_back(tbl[tbl.size() - 1]);
        run_prog("idle_readback");

        // Reset in the second wait cycle of a write: write dropped, counter cleared.
        tv(1, 1, 3'd2, 32'h1020, 32'h12345678, 32'h0, 0);
        prog.push_back(tbl[tbl.size() - 1]);
        run_prog("rst_prep");
        sel = 1'b1; t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_haddr = 32'h1020;
        t_hwrite = 1'b1; t_hsize = 3'd2;
        @(posedge HCLK); #1;
        t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_hwdata = 32'hFFFF_FFFF;
        @(negedge HCLK); chk("rst wait1 hreadyout", {31'h0, o_ready}, 32'h0);
        @(negedge HCLK); chk("rst wait2 hreadyout", {31'h0, o_ready}, 32'h0);
        #2 HRESET = 1'b1;
        #1 chk_idle("rst mid-wait");
        @(negedge HCLK); HRESET = 1'b0;
        @(posedge HCLK); #1;
        tv(1, 0, 3'd2, 32'h1020, 32'h0, 32'h12345678, 0);
        prog.push_back(tbl[tbl.size() - 1]);
        run_prog("rst_readback");

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < MW; w++)
                model_push(d[0], 1'b1, 3'd2, (d ? BASE1 : BASE0) + 4 * w, $urandom);
            run_prog($sformatf("fill%0d", d));
            for (int i = 0; i < 150; i++) begin
                logic [31:0] off;
                logic [2:0]  sz;
                int          r;
                r   = $urandom_range(0, 15);
                sz  = 3'($urandom_range(0, 2));
                off = $urandom_range(0, MEM_BYTES - 1);
                if (r != 0) off = off & ~((32'h1 << sz) - 32'h1);
                if (r == 1) off = off + MEM_BYTES;
                if (r == 2) off = 32'hFFFF_FFFC;
                if (r == 3) sz = 3'd3;
                model_push(d[0], 1'($urandom_range(0, 1)), sz, (d ? BASE1 : BASE0) + off, $urandom);
            end
            run_prog($sformatf("rand%0d", d));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_slave_sram.md
Name: ahb_slave_sram

Overview:
AHB-Lite slave that consumes the transfers driven by the team's AHB master and backs them with an internal word-organised SRAM. It pipelines address and data phases and supports byte, halfword and word sizes. Wait-state insertion is parameterised, and out-of-range or misaligned accesses receive a two-cycle ERROR response. It sits directly downstream of the master on the HADDR/HTRANS/HWDATA bus and returns HRDATA/HREADYOUT/HRESP.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; must be a power of two.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be aligned to MEM_WORDS*4.
WAIT_STATES, 0, HREADYOUT-low cycles inserted at the start of every OKAY data phase (0..15).

Ports:
HCLK  in  1  clock; all state updates on rising edge
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select from decoder
HREADY  in  1  bus ready (qualifies address phase)
HTRANS  in  type_htrans  IDLE/BUSY/NONSEQ/SEQ
HADDR  in  32  byte address
HSIZE  in  type_hsize  byte/half/word only
HBURST  in  type_hburst  accepted, ignored (slave is address-driven)
HWRITE  in  1  1=write
HWDATA  in  32  write data, data phase
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data

Behaviour:
- Clock is HCLK; reset is HRESET, asynchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=S_IDLE, wait counter=0, latched address-phase registers cleared. SRAM contents are not reset.
- Address phase accepted on a rising edge where HSEL & HREADY & HTRANS∈{NONSEQ,SEQ}. Latch word index, addr[1:0], HSIZE and HWRITE.
- IDLE/BUSY or HSEL=0 gives a zero-wait OKAY data phase with no memory access.
- Error check at acceptance:
  - ERROR if HADDR-BASE_ADDR ≥ MEM_WORDS*4.
  - ERROR if HSIZE>word.
  - ERROR if a halfword has addr[0]=1.
  - ERROR if a word has addr[1:0]≠0.
- FSM states S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2:
  - S_IDLE: HREADYOUT=1, HRESP=0. On a valid accept, go to S_WAIT (WAIT_STATES>0) or S_DATA. On an erroring accept, go to S_ERR1.
  - S_WAIT: HREADYOUT=0, HRESP=0. Counter increments each cycle; move to S_DATA when counter==WAIT_STATES-1.
  - S_DATA: HREADYOUT=1, HRESP=0; the data phase completes this cycle. Reads drive HRDATA=mem[index]. Writes update the selected byte lanes at the closing edge. A new accept on the same edge re-enters S_WAIT/S_DATA/S_ERR1 (back-to-back, no bubble); otherwise go to S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1; always go to S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=1. Accepts a new address phase normally. No write is ever performed for an errored transfer.
- Byte lanes are little-endian:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Read data is the full 32-bit word; the master selects lanes. HRDATA=0 outside a read S_DATA cycle.
- A read beat immediately following a write to the same word returns the newly written data.
- HREADY low with HSEL high: nothing is sampled and no state change occurs unless this slave is itself stalling.
- HRESET asserted mid-transfer: immediately return to reset values. Any pending write is dropped and the wait counter is cleared.

Decomposition:
- Package ahb: reuse type_htrans, type_hsize, type_hburst and the OKAY/ERROR constants.
- Package ahb additions:
  - Slave state enum type_slv_state.
  - Function byte_strobe(type_hsize, logic[1:0]) returning logic[3:0].
  - Function addr_ok(type_hsize, logic[1:0]).
- Sub-module ahb_sram_mem: MEM_WORDS×32 array with a 4-bit byte write enable, asynchronous read and synchronous write.

Test Plan:
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10 → HREADYOUT stays 1, HRESP=0, HRDATA=0xDEADBEEF in the read data phase.
- INCR4 word writes 0x1,0x2,0x3,0x4 @0x20..0x2C back-to-back, then INCR4 reads → no bubbles; reads return 1,2,3,4 in consecutive cycles.
- Byte write 0xAA @0x41 over word 0x11223344 @0x40, then halfword write 0x5566 @0x42 → word read @0x40 = 0x5566AA44.
- WAIT_STATES=2: single read → HREADYOUT low for exactly 2 cycles, then high with data.
- Word read @BASE+MEM_WORDS*4, and halfword @0x3 → HREADYOUT 0 then 1, HRESP=1 both cycles; a subsequent write to the erroring address leaves memory unchanged.
- Assert HRESET during S_WAIT of a write → outputs at reset values within the same cycle; target word unchanged after release.
